// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving an 8-bit combinational ALU core
//
// Purpose:
//   Accepts ALU commands over a valid/ready interface, registers the opcode
//   and operands that feed an external combinational ALU core, captures the
//   core result one cycle later and presents it over a valid/ready response
//   interface. An accumulator holds the last legal result so operation
//   chains can feed it back as operand A.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op, cmd_a, cmd_b      opcode and operands
//   cmd_use_acc               take operand A from the accumulator
//   alu_choice, alu_a, alu_b  registered inputs to the ALU core
//   alu_result, alu_carry,
//   alu_borrow                outputs of the ALU core
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_carry,
//   rsp_borrow, rsp_zero,
//   rsp_err                   captured response fields
//   acc                       accumulator
//   op_count                  completed responses, saturating at 16'hFFFF

module alu_cmd_sequencer #(
  parameter logic [7:0] ACC_INIT = 8'h00,
  parameter int         MAX_OP   = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_use_acc,
  output logic [4:0]  alu_choice,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_borrow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_carry,
  output logic        rsp_borrow,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [7:0]  acc,
  output logic [15:0] op_count
);

  localparam logic [4:0] LP_MAX_OP = 5'(MAX_OP);
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_MUL    = 5'd2;
  localparam logic [4:0] OP_INC    = 5'd15;
  localparam logic [4:0] OP_DEC    = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]  r_alu_choice;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [7:0]  r_rsp_result;
  logic        r_rsp_carry;
  logic        r_rsp_borrow;
  logic        r_rsp_zero;
  logic        r_rsp_err;
  logic [7:0]  r_acc;
  logic [15:0] r_op_count;

  logic w_accept;
  logic w_legal;
  logic w_carry_en;
  logic w_borrow_en;

  // Gated by rst so the port reads 0 throughout reset even though the
  // state register already sits in IDLE.
  assign cmd_ready   = (r_state == ST_IDLE) && !rst;
  assign rsp_valid   = (r_state == ST_RESP);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_legal     = (cmd_op <= LP_MAX_OP);

  // Only arithmetic ops whose flags are meaningful pass the core flags on;
  // everything else reports 0 whatever the core drives.
  assign w_carry_en  = (r_alu_choice == OP_ADD) || (r_alu_choice == OP_MUL) ||
                       (r_alu_choice == OP_INC);
  assign w_borrow_en = (r_alu_choice == OP_SUB) || (r_alu_choice == OP_DEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_legal ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_choice <= 5'd0;
      r_alu_a      <= 8'd0;
      r_alu_b      <= 8'd0;
      r_rsp_result <= 8'd0;
      r_rsp_carry  <= 1'b0;
      r_rsp_borrow <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_acc        <= ACC_INIT;
      r_op_count   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_alu_choice <= cmd_op;
              r_alu_a      <= cmd_use_acc ? r_acc : cmd_a;
              r_alu_b      <= cmd_b;
            end else begin
              // Illegal opcode: answer directly, core inputs untouched.
              r_rsp_result <= 8'd0;
              r_rsp_carry  <= 1'b0;
              r_rsp_borrow <= 1'b0;
              r_rsp_zero   <= 1'b0;
              r_rsp_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_carry  <= w_carry_en && alu_carry;
          r_rsp_borrow <= w_borrow_en && alu_borrow;
          r_rsp_zero   <= (alu_result == 8'd0);
          r_rsp_err    <= 1'b0;
          r_acc        <= alu_result;
        end
        ST_RESP: begin
          if (rsp_ready && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_choice = r_alu_choice;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_borrow = r_rsp_borrow;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign acc        = r_acc;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a behavioural ALU core

module tb_alu_cmd_sequencer;

  localparam logic [7:0] ACC_INIT = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_use_acc;
  logic [4:0]  alu_choice;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_borrow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  logic        rsp_borrow;
  logic        rsp_zero;
  logic        rsp_err;
  logic [7:0]  acc;
  logic [15:0] op_count;

  // extra flag bits the core model ORs onto its carry/borrow outputs
  logic        nz_c = 1'b0;
  logic        nz_b = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;

  // reference model state
  logic [7:0]  m_acc;
  logic [15:0] m_count;
  logic [20:0] m_alu;   // {choice, a, b}

  logic [12:0] got;
  logic [12:0] exp_v;
  logic [9:0]  w_core;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.ACC_INIT(ACC_INIT), .MAX_OP(19)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_choice(alu_choice), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_borrow(rsp_borrow), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .acc(acc), .op_count(op_count)
  );

  // Behavioural ALU: returns {carry, borrow, result}
  function automatic logic [9:0] core_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    core_fn = 10'd0;
    case (op)
      5'd0:  begin s = {1'b0, a} + {1'b0, b}; core_fn = {s[8], 1'b0, s[7:0]}; end
      5'd1:  core_fn = {1'b0, (a < b), 8'(a - b)};
      5'd2:  begin p = a * b; core_fn = {(p[15:8] != 0), 1'b0, p[7:0]}; end
      5'd3:  core_fn = {2'b00, a & b};
      5'd4:  core_fn = {2'b00, a | b};
      5'd5:  core_fn = {2'b00, a ^ b};
      5'd6:  core_fn = {2'b00, ~a};
      5'd7:  core_fn = {a[7], 1'b0, a[6:0], 1'b0};
      5'd8:  core_fn = {1'b0, a[0], 1'b0, a[7:1]};
      5'd9:  core_fn = {2'b00, a[6:0], a[7]};
      5'd10: core_fn = {1'b0, a[0], a[0], a[7:1]};
      5'd11: core_fn = {2'b00, 7'd0, ($signed(a) < $signed(b))};
      5'd12: core_fn = {2'b00, 7'd0, (a < b)};
      5'd13: core_fn = {2'b00, 7'd0, (a == b)};
      5'd14: core_fn = {2'b00, 7'd0, (a != b)};
      5'd15: core_fn = {(a == 8'hFF), 1'b0, 8'(a + 8'd1)};
      5'd16: core_fn = {1'b0, (a == 8'h00), 8'(a - 8'd1)};
      5'd17: core_fn = {2'b00, a[7] ? 8'(-a) : a};
      5'd18: core_fn = {2'b00, a};
      5'd19: core_fn = {2'b00, b};
      default: core_fn = 10'd0;
    endcase
  endfunction

  assign w_core     = core_fn(alu_choice, alu_a, alu_b);
  assign alu_result = w_core[7:0];
  assign alu_carry  = w_core[9] | nz_c;
  assign alu_borrow = w_core[8] | nz_b;

  // Expected {result, carry, borrow, zero, err} for a legal command.
  function automatic logic [11:0] exp_rsp(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic c_nz, input logic b_nz);
    logic [9:0] f;
    logic       c;
    logic       bw;
    f  = core_fn(op, a, b);
    c  = (op == 5'd0 || op == 5'd2 || op == 5'd15) ? (f[9] | c_nz) : 1'b0;
    bw = (op == 5'd1 || op == 5'd16) ? (f[8] | b_nz) : 1'b0;
    return {f[7:0], c, bw, (f[7:0] == 8'd0), 1'b0};
  endfunction

  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err,
         alu_choice, alu_a, alu_b, acc, op_count} !== {2'b00, 13'd0, 21'd0, ACC_INIT, 16'd0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h alu=%h/%h/%h acc=%h cnt=%0d, want all zero acc=%h",
               cmd_ready, rsp_valid, rsp_result, alu_choice, alu_a, alu_b, acc, op_count, ACC_INIT);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    m_acc = ACC_INIT; m_count = 16'd0; m_alu = 21'd0;
  endtask

  task automatic test_add_chain;
    send(5'd0, 8'hF0, 8'h20, 1'b0);
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b00) begin
      n_err++; $display("FAIL add_t1: got vld=%b rdy=%b want 0 0", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
    n_vec++;
    if (got !== {1'b1, 8'h10, 4'b1000}) begin
      n_err++; $display("FAIL add_rsp: got %h want %h", got, {1'b1, 8'h10, 4'b1000});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, cmd_ready, acc, op_count} !== {2'b01, 8'h10, 16'd1}) begin
      n_err++; $display("FAIL add_hs: got vld=%b rdy=%b acc=%h cnt=%0d want 0 1 10 1", rsp_valid, cmd_ready, acc, op_count);
    end
    send(5'd15, 8'h55, 8'h00, 1'b1);
    n_vec++;
    if (alu_a !== 8'h10) begin
      n_err++; $display("FAIL chain_alu_a: got %h want 10", alu_a);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({rsp_valid, rsp_result, acc} !== {1'b1, 8'h11, 8'h11}) begin
      n_err++; $display("FAIL chain_rsp: got vld=%b res=%h acc=%h want 1 11 11", rsp_valid, rsp_result, acc);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    m_acc = 8'h11; m_count = 16'd2; m_alu = {5'd15, 8'h10, 8'h00};
  endtask

  task automatic test_sub_ror;
    send(5'd1, 8'h05, 8'h07, 1'b0);
    @(posedge clk); #1;
    got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
    n_vec++;
    if (got !== {1'b1, 8'hFE, 4'b0100}) begin
      n_err++; $display("FAIL sub_rsp: got %h want %h", got, {1'b1, 8'hFE, 4'b0100});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    nz_b = 1'b1;
    send(5'd10, 8'h01, 8'h00, 1'b0);
    @(posedge clk); #1;
    got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
    n_vec++;
    if (got !== {1'b1, 8'h80, 4'b0000}) begin
      n_err++; $display("FAIL ror_borrow_mask: got %h want %h", got, {1'b1, 8'h80, 4'b0000});
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    nz_b = 1'b0;
    m_acc = 8'h80; m_count = m_count + 16'd2; m_alu = {5'd10, 8'h01, 8'h00};
  endtask

  task automatic test_illegal;
    send(5'h1F, 8'hAA, 8'hBB, 1'b0);
    got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
    n_vec++;
    if (got !== {1'b1, 8'h00, 4'b0001}) begin
      n_err++; $display("FAIL illegal_rsp_t1: got %h want %h", got, {1'b1, 8'h00, 4'b0001});
    end
    n_vec++;
    if ({alu_choice, alu_a, alu_b, acc} !== {m_alu, m_acc}) begin
      n_err++; $display("FAIL illegal_unchanged: got alu=%h acc=%h want alu=%h acc=%h",
                        {alu_choice, alu_a, alu_b}, acc, m_alu, m_acc);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    m_count++;
    n_vec++;
    if ({rsp_valid, cmd_ready, op_count} !== {2'b01, m_count}) begin
      n_err++; $display("FAIL illegal_hs: got vld=%b rdy=%b cnt=%0d want 0 1 %0d", rsp_valid, cmd_ready, op_count, m_count);
    end
  endtask

  task automatic test_backpressure;
    logic [12:0] held;
    send(5'd5, 8'h3C, 8'hA5, 1'b0);
    @(posedge clk); #1;
    m_acc = 8'h99; m_alu = {5'd5, 8'h3C, 8'hA5};
    held = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
    n_vec++;
    if (held !== {1'b1, 8'h99, 4'b0000}) begin
      n_err++; $display("FAIL bp_rsp: got %h want %h", held, {1'b1, 8'h99, 4'b0000});
    end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 5'($urandom_range(0, 19));
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_use_acc = 1'($urandom);
      nz_c = 1'($urandom); nz_b = 1'($urandom);
      @(posedge clk); #1;
      got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
      n_vec++;
      if ({got, cmd_ready, acc, alu_choice, alu_a, alu_b} !== {held, 1'b0, m_acc, m_alu}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got rsp=%h rdy=%b acc=%h alu=%h want %h 0 %h %h",
                          i, got, cmd_ready, acc, {alu_choice, alu_a, alu_b}, held, m_acc, m_alu);
      end
    end
    cmd_valid = 1'b0; nz_c = 1'b0; nz_b = 1'b0;
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    m_count++;
    n_vec++;
    if ({rsp_valid, cmd_ready, op_count} !== {2'b01, m_count}) begin
      n_err++; $display("FAIL bp_release: got vld=%b rdy=%b cnt=%0d want 0 1 %0d", rsp_valid, cmd_ready, op_count, m_count);
    end
  endtask

  task automatic test_reset_mid;
    send(5'd2, 8'h10, 8'h10, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err,
         alu_choice, alu_a, alu_b, acc, op_count} !== {2'b00, 13'd0, 21'd0, ACC_INIT, 16'd0}) begin
      n_err++;
      $display("FAIL reset_mid_async: got rdy=%b vld=%b res=%h alu=%h/%h/%h acc=%h cnt=%0d",
               cmd_ready, rsp_valid, rsp_result, alu_choice, alu_a, alu_b, acc, op_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_mid_release: got rdy=%b vld=%b want 1 0", cmd_ready, rsp_valid);
    end
    m_acc = ACC_INIT; m_count = 16'd0;
    send(5'd0, 8'h01, 8'h01, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if ({rsp_valid, rsp_result, rsp_err, acc} !== {1'b1, 8'h02, 1'b0, 8'h02}) begin
      n_err++; $display("FAIL reset_mid_fresh_add: got vld=%b res=%h err=%b acc=%h want 1 02 0 02",
                        rsp_valid, rsp_result, rsp_err, acc);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    m_acc = 8'h02; m_count = 16'd1; m_alu = {5'd0, 8'h01, 8'h01};
  endtask

  task automatic test_random;
    logic [4:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  a_eff;
    logic        ua;
    int          dly;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      a = 8'($urandom); b = 8'($urandom); ua = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      nz_c = 1'($urandom); nz_b = 1'($urandom);
      a_eff = ua ? m_acc : a;
      send(op, a, b, ua);
      if (op <= 5'd19) begin
        m_alu = {op, a_eff, b};
        n_vec++;
        if ({rsp_valid, alu_choice, alu_a, alu_b} !== {1'b0, m_alu}) begin
          n_err++; $display("FAIL rnd_exec[%0d]: got vld=%b alu=%h want 0 %h", i, rsp_valid, {alu_choice, alu_a, alu_b}, m_alu);
        end
        exp_v = {1'b1, exp_rsp(op, a_eff, b, nz_c, nz_b)};
        m_acc = exp_v[11:4];
        @(posedge clk); #1;
      end else begin
        exp_v = {1'b1, 8'h00, 4'b0001};
      end
      got = {rsp_valid, rsp_result, rsp_carry, rsp_borrow, rsp_zero, rsp_err};
      n_vec++;
      if ({got, acc, alu_choice, alu_a, alu_b} !== {exp_v, m_acc, m_alu}) begin
        n_err++; $display("FAIL rnd_rsp[%0d] op=%0d: got rsp=%h acc=%h alu=%h want %h %h %h",
                          i, op, got, acc, {alu_choice, alu_a, alu_b}, exp_v, m_acc, m_alu);
      end
      dly = $urandom_range(0, 2);
      repeat (dly) begin
        cmd_valid = 1'b1; cmd_op = 5'($urandom); cmd_a = 8'($urandom);
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
      m_count++;
      n_vec++;
      if ({rsp_valid, cmd_ready, acc, op_count} !== {2'b01, m_acc, m_count}) begin
        n_err++; $display("FAIL rnd_hs[%0d]: got vld=%b rdy=%b acc=%h cnt=%0d want 0 1 %h %0d",
                          i, rsp_valid, cmd_ready, acc, op_count, m_acc, m_count);
      end
    end
    nz_c = 1'b0; nz_b = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add_chain;
    test_sub_ror;
    test_illegal;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator for the team's 8-bit combinational ALU core. Accepts operation commands over a valid/ready interface and drives the core's operand and opcode inputs from registers. Captures the core's result and flags, then returns them over a valid/ready response interface. Keeps an accumulator so operation chains need no external operand feedback.

Parameters:
ACC_INIT, 8'h00, reset/initial value of the accumulator
MAX_OP, 19, highest legal opcode; codes above it are illegal

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  5  opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 SHL, 8 SHR, 9 ROL, 10 ROR, 11 SLT, 12 ULT, 13 EQ, 14 NE, 15 INC, 16 DEC, 17 ABS, 18 PASSA, 19 PASSB
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_use_acc  input  1  take A from the accumulator; cmd_a is ignored
alu_choice  output  5  opcode driven to the ALU core
alu_a  output  8  A driven to the ALU core
alu_b  output  8  B driven to the ALU core
alu_result  input  8  result from the ALU core
alu_carry  input  1  carry_out from the ALU core
alu_borrow  input  1  borrow_out from the ALU core
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_result  output  8  captured result
rsp_carry  output  1  masked carry
rsp_borrow  output  1  masked borrow
rsp_zero  output  1  rsp_result == 0
rsp_err  output  1  illegal opcode
acc  output  8  accumulator
op_count  output  16  completed responses, saturating

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - cmd_ready = 0 while rst is asserted, then 1 from the first cycle after release.
  - alu_choice, alu_a, alu_b = 0.
  - All rsp_* outputs = 0.
  - acc = ACC_INIT.
  - op_count = 0.
- FSM states: IDLE, EXEC, RESP.
  - cmd_ready = 1 only in IDLE.
  - rsp_valid = 1 only in RESP.
- IDLE, on cmd_valid & cmd_ready (cycle T):
  - Legal opcode (cmd_op <= MAX_OP): register alu_choice = cmd_op, alu_a = cmd_use_acc ? acc : cmd_a, alu_b = cmd_b. Go to EXEC.
  - Illegal opcode: leave the alu_* registers unchanged. Load rsp_result = 0, rsp_carry = 0, rsp_borrow = 0, rsp_zero = 0, rsp_err = 1. Go to RESP; rsp_valid rises at T+1. acc is unchanged.
- EXEC (cycle T+1), one cycle:
  - The core output settles combinationally from the registered inputs.
  - At the end of the cycle, capture rsp_result = alu_result and rsp_err = 0.
  - rsp_zero = (alu_result == 0).
  - rsp_carry = alu_carry only for ADD, MUL and INC; otherwise 0.
  - rsp_borrow = alu_borrow only for SUB and DEC; otherwise 0. The borrow is forced to 0 on all other opcodes (including ROR) regardless of the core output.
  - acc <= alu_result.
  - Go to RESP; rsp_valid is 1 at T+2.
- RESP:
  - All rsp_* outputs hold stable while rsp_ready = 0.
  - On rsp_ready: go to IDLE and increment op_count (saturates at 16'hFFFF); illegal-opcode responses count too. rsp_valid drops the next cycle.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- Command inputs are ignored outside IDLE; no buffering or dropping side effects.
- alu_* outputs hold their last value in IDLE and RESP, and change only on a legal accept.
- Latency and throughput:
  - Legal command: accept to rsp_valid = 2 cycles; at most 1 command per 3 cycles.
  - Illegal command: 1 cycle.
- Reset mid-operation: an assertion in any state aborts immediately and asynchronously to the reset values. The in-flight command is lost and acc returns to ACC_INIT.
- Accumulator chaining: cmd_use_acc samples acc in the accept cycle. acc always reflects the last completed legal operation before that accept.

Test Plan:
- ADD, cmd_a = 0xF0, cmd_b = 0x20 -> rsp_valid at T+2, rsp_result = 0x10, rsp_carry = 1, rsp_borrow = 0, rsp_zero = 0, acc = 0x10, op_count = 1 after the handshake.
- Chain: after the ADD above, INC with cmd_use_acc = 1 and cmd_a = 0x55 -> alu_a = 0x10, rsp_result = 0x11, acc = 0x11.
- SUB 0x05 - 0x07 -> rsp_result = 0xFE, rsp_borrow = 1, rsp_carry = 0. ROR on 0x01 with the core borrow forced to 1 -> rsp_result = 0x80, rsp_borrow = 0.
- Illegal cmd_op = 0x1F -> rsp_valid at T+1, rsp_err = 1, rsp_result = 0x00, acc and alu_* unchanged, op_count increments after the handshake.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid while pulsing cmd_valid with other ops -> rsp_* stable, cmd_ready = 0, no acc change. Release rsp_ready -> IDLE on the next cycle.
- Assert rst during EXEC of MUL 0x10 * 0x10 -> all outputs at reset values in the same cycle, acc = ACC_INIT, no response issued. After release, cmd_ready = 1 and a fresh ADD 1 + 1 returns 0x02.
